instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: requests one word per instruction, issues it to the
// control unit for one cycle, and handles run/step/halt sequencing.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset; waits for start (ignored while halt_req=1)
// REQ    | imem_re=1 with imem_addr=pc for one cycle
// WAIT   | read data returns; captured into ir; HALT_OP stops here
// ISSUE  | instr_valid=1, opcode/k from ir; pc advances at cycle end
// PAUSE  | single-step hold; step or step_mode=0 resumes fetching
// HALT   | halted=1; start restarts from pc=0
module instr_fetch #(
  parameter int         PC_W    = 8,
  parameter logic [6:0] NOP_OP  = 7'h7F,
  parameter logic [6:0] HALT_OP = 7'h7E
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  input  logic            step_mode,
  input  logic            step,
  output logic            imem_re,
  output logic [PC_W-1:0] imem_addr,
  input  logic [14:0]     imem_rdata,
  output logic [6:0]      opcode,
  output logic [7:0]      k,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_PAUSE = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [14:0]     ir;
  logic            ir_load;
  logic            pc_inc;
  logic            pc_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= imem_rdata;
      if (pc_clr)      pc <= '0;
      else if (pc_inc) pc <= pc + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_clr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !halt_req) state_nxt = S_REQ;
      end
      S_REQ: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Decide on the returning word directly; ir is loaded on the same edge.
        ir_load = 1'b1;
        if (imem_rdata[14:8] == HALT_OP) state_nxt = S_HALT;
        else                             state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        pc_inc = 1'b1;
        if (halt_req)       state_nxt = S_HALT;
        else if (step_mode) state_nxt = S_PAUSE;
        else                state_nxt = S_REQ;
      end
      S_PAUSE: begin
        if (halt_req)                state_nxt = S_HALT;
        else if (step || !step_mode) state_nxt = S_REQ;
      end
      S_HALT: begin
        if (start) begin
          pc_clr    = 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state register so reset forces them at once.
  assign imem_re     = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_ISSUE);
  assign opcode      = instr_valid ? ir[14:8] : NOP_OP;
  assign k           = instr_valid ? ir[7:0]  : 8'h00;
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected issues (word, pc, cycle),
// a negedge monitor pops and compares every instr_valid pulse.
module tb_instr_fetch;

  localparam logic [6:0] NOP  = 7'h7F;
  localparam logic [6:0] HOP  = 7'h7E;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, halt_req = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic        imem_re, instr_valid, halted;
  logic [7:0]  imem_addr, pc;
  logic [14:0] imem_rdata = '0;
  logic [6:0]  opcode;
  logic [7:0]  k;

  logic        start2 = 1'b0;
  logic        imem_re2, instr_valid2, halted2;
  logic [1:0]  imem_addr2, pc2;
  logic [14:0] imem_rdata2 = '0;
  logic [6:0]  opcode2;
  logic [7:0]  k2;

  logic [14:0] mem [256];
  logic [14:0] mem2 [4];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [6:0] op;
    logic [7:0] kk;
    logic [7:0] pcv;
    int         at;
  } exp_t;
  exp_t sb[$];

  instr_fetch #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .step_mode(step_mode), .step(step), .imem_re(imem_re),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .opcode(opcode),
    .k(k), .instr_valid(instr_valid), .pc(pc), .halted(halted)
  );

  instr_fetch #(.PC_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .halt_req(1'b0),
    .step_mode(1'b0), .step(1'b0), .imem_re(imem_re2),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .opcode(opcode2),
    .k(k2), .instr_valid(instr_valid2), .pc(pc2), .halted(halted2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_re)  imem_rdata  <= mem[imem_addr];
    if (imem_re2) imem_rdata2 <= mem2[imem_addr2];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue", {25'd0, opcode}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("issue_opcode", {25'd0, opcode}, {25'd0, e.op});
          chk("issue_k", {24'd0, k}, {24'd0, e.kk});
          chk("issue_pc", {24'd0, pc}, {24'd0, e.pcv});
          chk("issue_cycle", cyc, e.at);
        end
      end else begin
        chk("idle_nop", {17'd0, opcode, k}, {17'd0, NOP, 8'h00});
      end
    end
  end

  task automatic expect_issue(input logic [14:0] w, input logic [7:0] p, input int at);
    exp_t e;
    e.op = w[14:8]; e.kk = w[7:0]; e.pcv = p; e.at = at;
    sb.push_back(e);
  endtask

  task automatic pulse_start(output int n);
    @(negedge clk);
    start = 1'b1;
    n = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (halted) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) chk("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_re"}, {31'd0, imem_re}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_opcode"}, {25'd0, opcode}, {25'd0, NOP});
    chk({tag, "_k"}, {24'd0, k}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_pc"}, {24'd0, pc}, 32'd0);
  endtask

  initial begin
    int n, m, p, at;
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = {HOP, 8'h00};
    for (int i = 0; i < 4; i++) mem2[i] = {7'h24, 8'(i)};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // single ADD A,5 then HALT at address 1
    mem[0] = 15'h0405; mem[1] = {HOP, 8'h00};
    pulse_start(n);
    expect_issue(15'h0405, 8'd0, n + 3);
    chk("first_imem_re", {31'd0, imem_re}, 32'd1);
    chk("first_imem_addr", {24'd0, imem_addr}, 32'd0);
    repeat (3) @(negedge clk);
    chk("pc_after_issue", {24'd0, pc}, 32'd1);
    wait_halted(20, at);
    chk("halt_cycle_1", at, n + 6);
    chk("halt_pc_1", {24'd0, pc}, 32'd1);

    // free run: three issues 3 cycles apart, halt at address 3
    mem[0] = {7'h00, 8'h11}; mem[1] = {7'h06, 8'h22};
    mem[2] = {7'h08, 8'h33}; mem[3] = {HOP, 8'h44};
    pulse_start(n);
    expect_issue({7'h00, 8'h11}, 8'd0, n + 3);
    expect_issue({7'h06, 8'h22}, 8'd1, n + 6);
    expect_issue({7'h08, 8'h33}, 8'd2, n + 9);
    wait_halted(40, at);
    chk("halt_cycle_run", at, n + 12);
    chk("halt_pc_run", {24'd0, pc}, 32'd3);
    repeat (3) @(negedge clk);
    chk("halted_hold", {31'd0, halted}, 32'd1);
    chk("halted_opcode", {25'd0, opcode}, {25'd0, NOP});

    // single-step: issue, pause (start/no fetch), step, then resume free-run
    mem[0] = 15'h1001; mem[1] = 15'h1102; mem[2] = 15'h1203; mem[3] = {HOP, 8'h00};
    step_mode = 1'b1;
    pulse_start(n);
    expect_issue(15'h1001, 8'd0, n + 3);
    repeat (3) @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      if (imem_re) seen = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("pause_no_fetch", {31'd0, seen}, 32'd0);
    chk("pause_pc", {24'd0, pc}, 32'd1);
    step = 1'b1;
    m = cyc;
    expect_issue(15'h1102, 8'd1, m + 3);
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    step_mode = 1'b0;
    p = cyc;
    expect_issue(15'h1203, 8'd2, p + 3);
    wait_halted(40, at);
    chk("step_halt_cycle", at, p + 6);
    chk("step_halt_pc", {24'd0, pc}, 32'd3);

    // halt_req during WAIT: instruction still issues, then HALT; restart from pc=0
    mem[0] = 15'h2001; mem[1] = {HOP, 8'h00};
    pulse_start(n);
    expect_issue(15'h2001, 8'd0, n + 3);
    @(negedge clk);
    halt_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("halt_req_halted", {31'd0, halted}, 32'd1);
    chk("halt_req_pc", {24'd0, pc}, 32'd1);
    halt_req = 1'b0;
    pulse_start(n);
    expect_issue(15'h2001, 8'd0, n + 3);
    chk("restart_addr", {24'd0, imem_addr}, 32'd0);
    wait_halted(20, at);
    chk("restart_halt_cycle", at, n + 6);

    // reset in WAIT, then start blocked by halt_req, then normal start
    mem[0] = 15'h3001; mem[1] = {HOP, 8'h00};
    pulse_start(n);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    halt_req = 1'b1;
    pulse_start(n);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (imem_re) seen = 1'b1;
      @(negedge clk);
    end
    chk("start_blocked", {31'd0, seen}, 32'd0);
    halt_req = 1'b0;
    pulse_start(n);
    expect_issue(15'h3001, 8'd0, n + 3);
    wait_halted(20, at);
    chk("post_rst_halt_cycle", at, n + 6);

    // PC_W=2 wraps 0,1,2,3,0,1 without halting
    @(negedge clk);
    start2 = 1'b1;
    n = cyc;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int t = 0;
      while (!instr_valid2 && t < 12) begin
        @(negedge clk);
        t++;
      end
      chk("w2_cycle", cyc, n + 3 + 3 * i);
      chk("w2_pc", {30'd0, pc2}, 32'(i % 4));
      chk("w2_k", {24'd0, k2}, 32'(i % 4));
      chk("w2_opcode", {25'd0, opcode2}, 32'h24);
      chk("w2_not_halted", {31'd0, halted2}, 32'd0);
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queue_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
